cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run-control initiator that produces the cpu_start / quit_cmd pulse protocol consumed by the CPU status block.
- Converts monitor-side commands (start, step-N, stop) into start and quit pulses.
- Adds a PC breakpoint and memory-calibration gating.
- Reports the stop cause back to the monitor once the pipeline reset has drained.

Parameters:
- DRAIN_CYCLES, 4: cycles held in DRAIN after quit_cmd before returning to IDLE. Covers the rst_pipe propagation chain.
- STEP_W, 16: width of the step counter and the step_num input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_calib_complete  in  1  DRAM calibration done
- cmd_start  in  1  1-cycle pulse: free run
- cmd_step  in  1  1-cycle pulse: run step_num executing cycles
- cmd_stop  in  1  1-cycle pulse: halt
- step_num  in  STEP_W  step count, sampled on cmd_step
- bp_en  in  1  breakpoint enable (level)
- bp_addr  in  32  breakpoint PC
- pc_id  in  32  PC of the instruction in the ID stage
- pc_id_valid  in  1  pc_id holds a real instruction
- stall  in  1  CPU stall from the status block
- cpu_start  out  1  1-cycle start pulse to the status block
- quit_cmd  out  1  1-cycle quit pulse to the status block
- cpu_running  out  1  state is RUN
- stop_valid  out  1  1-cycle pulse when DRAIN completes
- stop_cause  out  2  0 user stop, 1 step done, 2 breakpoint, 3 calibration lost; held until next stop

Behaviour:
- All outputs are registered. Reset values: every output 0, stop_cause 0, state IDLE, counters 0, bp_armed 0.
- States are IDLE, WAIT_CALIB, RUN, DRAIN.
- IDLE:
  - On cmd_start or cmd_step:
    - If init_calib_complete=1: cpu_start=1 the next cycle and go to RUN.
    - Otherwise: go to WAIT_CALIB, with no pulse.
  - cmd_step also loads step_cnt from step_num; step_num=0 loads 1. cmd_start sets step_mode=0; cmd_step sets step_mode=1.
  - Simultaneous cmd_start and cmd_step: cmd_step wins.
  - cmd_stop is ignored in IDLE.
- WAIT_CALIB:
  - When init_calib_complete rises: cpu_start pulse, then RUN.
  - cmd_stop returns to IDLE with stop_cause=0 and a stop_valid pulse. No quit_cmd, because the CPU never started.
- RUN:
  - cpu_running=1.
  - An executing cycle is a cycle with stall=0.
  - bp_armed is cleared on entry and set after the first executing cycle. This lets execution resume from a breakpoint address.
  - Quit conditions are evaluated each cycle in this priority order:
    1. ~init_calib_complete gives cause 3.
    2. cmd_stop gives cause 0.
    3. bp_en & bp_armed & pc_id_valid & ~stall & pc_id==bp_addr gives cause 2.
    4. step_mode & ~stall & step_cnt==1 gives cause 1.
  - In step mode, step_cnt decrements on each executing cycle. It saturates at 0 and never wraps.
  - On any quit condition: quit_cmd=1 the next cycle (exactly one pulse), stop_cause latched, go to DRAIN.
  - cmd_start and cmd_step are ignored in RUN.
- DRAIN:
  - drain_cnt counts DRAIN_CYCLES cycles.
  - Then stop_valid pulses for one cycle and the state returns to IDLE.
  - All commands in DRAIN are dropped; they are not queued.
- Protocol guarantees:
  - cpu_start and quit_cmd are never high in the same cycle.
  - Consecutive pulses are separated by at least DRAIN_CYCLES+1 cycles.
- rst_n asserted in any state: immediate return to reset values, with no quit_cmd issued.

Test Plan:
- Calib=1, cmd_start at cycle 10 -> cpu_start high only at cycle 11, cpu_running=1 from cycle 11. cmd_stop at cycle 30 -> quit_cmd at cycle 31, stop_valid with cause 0 at cycle 36 (DRAIN_CYCLES=4).
- cmd_step with step_num=5, stall=0 except 3 stall cycles inserted -> quit_cmd exactly after the 5th executing cycle, cause 1. step_num=0 -> single executing cycle, cause 1.
- bp_en=1, bp_addr=0x100, pc_id sequence 0xF8, 0xFC, 0x100 with pc_id_valid=1 -> quit after 0x100, cause 2. Restart with pc_id=0x100 on the first executing cycle -> no immediate quit.
- cmd_start with calib=0 -> no cpu_start. Calib rises 20 cycles later -> cpu_start the next cycle. Separate run: cmd_stop while in WAIT_CALIB -> stop_valid with cause 0 and no quit_cmd.
- In RUN, drop calib while cmd_stop and a breakpoint match occur in the same cycle -> single quit_cmd, cause 3. Commands issued during DRAIN -> no effect.
- Assert rst_n=0 mid-RUN -> all outputs 0 immediately, no quit_cmd. After release, cmd_start works normally.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the monitor/CPU side and cpu_run_ctrl.
// The master drives commands and CPU observations; the slave (cpu_run_ctrl) returns pulses.
interface cpu_run_ctrl_if #(
    parameter int unsigned STEP_W = 16
);
    logic              init_calib_complete;
    logic              cmd_start;
    logic              cmd_step;
    logic              cmd_stop;
    logic [STEP_W-1:0] step_num;
    logic              bp_en;
    logic [31:0]       bp_addr;
    logic [31:0]       pc_id;
    logic              pc_id_valid;
    logic              stall;
    logic              cpu_start;
    logic              quit_cmd;
    logic              cpu_running;
    logic              stop_valid;
    logic [1:0]        stop_cause;

    modport master (
        output init_calib_complete, cmd_start, cmd_step, cmd_stop, step_num,
               bp_en, bp_addr, pc_id, pc_id_valid, stall,
        input  cpu_start, quit_cmd, cpu_running, stop_valid, stop_cause
    );

    modport slave (
        input  init_calib_complete, cmd_start, cmd_step, cmd_stop, step_num,
               bp_en, bp_addr, pc_id, pc_id_valid, stall,
        output cpu_start, quit_cmd, cpu_running, stop_valid, stop_cause
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control initiator: turns monitor start/step/stop commands into cpu_start and
// quit_cmd pulses, adds a PC breakpoint and calibration gating, and reports the stop
// cause once the pipeline reset has drained.
module cpu_run_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned STEP_W       = 16
) (
    input logic         clk,
    input logic         rst_n,
    cpu_run_ctrl_if.slave bus
);
    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StWaitCalib = 2'd1;
    localparam logic [1:0] StRun       = 2'd2;
    localparam logic [1:0] StDrain     = 2'd3;

    localparam logic [1:0] CauseUser  = 2'd0;
    localparam logic [1:0] CauseStep  = 2'd1;
    localparam logic [1:0] CauseBp    = 2'd2;
    localparam logic [1:0] CauseCalib = 2'd3;

    localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES);
    localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);
    localparam logic [STEP_W-1:0] StepOne   = STEP_W'(1);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_mode_q, step_mode_d;
    logic              bp_armed_q, bp_armed_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              start_q, start_d;
    logic              quit_q, quit_d;
    logic              running_q, running_d;
    logic              stop_valid_q, stop_valid_d;

    logic              exec_cycle;
    logic              quit_hit;
    logic [1:0]        quit_cause;

    assign exec_cycle = ~bus.stall;

    // Prioritised quit condition while running; calibration loss outranks everything.
    always_comb begin
        quit_hit   = 1'b1;
        quit_cause = CauseUser;
        if (!bus.init_calib_complete) begin
            quit_cause = CauseCalib;
        end else if (bus.cmd_stop) begin
            quit_cause = CauseUser;
        end else if (bus.bp_en && bp_armed_q && bus.pc_id_valid && exec_cycle &&
                     (bus.pc_id == bus.bp_addr)) begin
            quit_cause = CauseBp;
        end else if (step_mode_q && exec_cycle && (step_cnt_q == StepOne)) begin
            quit_cause = CauseStep;
        end else begin
            quit_hit = 1'b0;
        end
    end

    // Next-state and next-output computation for the run-control FSM.
    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        step_mode_d  = step_mode_q;
        bp_armed_d   = bp_armed_q;
        drain_cnt_d  = drain_cnt_q;
        cause_d      = cause_q;
        start_d      = 1'b0;
        quit_d       = 1'b0;
        stop_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                // cmd_step wins over a simultaneous cmd_start.
                if (bus.cmd_step) begin
                    step_mode_d = 1'b1;
                    step_cnt_d  = (bus.step_num == '0) ? StepOne : bus.step_num;
                end else if (bus.cmd_start) begin
                    step_mode_d = 1'b0;
                end
                if (bus.cmd_start || bus.cmd_step) begin
                    if (bus.init_calib_complete) begin
                        state_d    = StRun;
                        start_d    = 1'b1;
                        bp_armed_d = 1'b0;
                    end else begin
                        state_d = StWaitCalib;
                    end
                end
            end
            StWaitCalib: begin
                // The CPU never started, so a stop here needs no quit pulse.
                if (bus.cmd_stop) begin
                    state_d      = StIdle;
                    cause_d      = CauseUser;
                    stop_valid_d = 1'b1;
                end else if (bus.init_calib_complete) begin
                    state_d    = StRun;
                    start_d    = 1'b1;
                    bp_armed_d = 1'b0;
                end
            end
            StRun: begin
                // Arm only after one executing cycle so a run can resume from bp_addr.
                if (exec_cycle) begin
                    bp_armed_d = 1'b1;
                    if (step_mode_q && (step_cnt_q != '0)) begin
                        step_cnt_d = step_cnt_q - StepOne;
                    end
                end
                if (quit_hit) begin
                    state_d     = StDrain;
                    quit_d      = 1'b1;
                    cause_d     = quit_cause;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                // Commands arriving here are dropped, not queued.
                if (drain_cnt_q == DrainLast) begin
                    state_d      = StIdle;
                    stop_valid_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        running_d = (state_d == StRun);
    end

    // State and registered outputs; reset clears everything without a quit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            step_cnt_q   <= '0;
            step_mode_q  <= 1'b0;
            bp_armed_q   <= 1'b0;
            drain_cnt_q  <= '0;
            cause_q      <= CauseUser;
            start_q      <= 1'b0;
            quit_q       <= 1'b0;
            running_q    <= 1'b0;
            stop_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            step_mode_q  <= step_mode_d;
            bp_armed_q   <= bp_armed_d;
            drain_cnt_q  <= drain_cnt_d;
            cause_q      <= cause_d;
            start_q      <= start_d;
            quit_q       <= quit_d;
            running_q    <= running_d;
            stop_valid_q <= stop_valid_d;
        end
    end

    assign bus.cpu_start   = start_q;
    assign bus.quit_cmd    = quit_q;
    assign bus.cpu_running = running_q;
    assign bus.stop_valid  = stop_valid_q;
    assign bus.stop_cause  = cause_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed pulse cycles.
module tb_cpu_run_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;

    cpu_run_ctrl_if #(.STEP_W(16)) bus ();

    cpu_run_ctrl #(
        .DRAIN_CYCLES(D),
        .STEP_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: run/wait flags, step budget, executed-cycle count and
    // the cycle number of the last quit pulse (drain is derived from that timestamp).
    bit       m_run, m_wait, m_mode;
    int       m_steps, m_exec;
    int       m_quit_cyc = -1;
    logic [1:0] m_cause;
    bit       e_start, e_quit, e_sv;

    int n_start = 0, n_quit = 0, n_sv = 0;
    int last_start = -1, last_quit = -1, last_sv = -1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_mode = 0; m_steps = 0; m_exec = 0;
        m_quit_cyc = -1; m_cause = 2'd0;
        e_start = 0; e_quit = 0; e_sv = 0;
    endtask

    task automatic model_step();
        bit exec;
        bit hit;
        logic [1:0] c;
        cyc++;
        e_start = 0; e_quit = 0; e_sv = 0;
        exec = !bus.stall;
        if (m_quit_cyc >= 0 && cyc <= m_quit_cyc + D + 1) begin
            if (cyc == m_quit_cyc + D + 1) begin
                e_sv = 1;
                m_quit_cyc = -1;
            end
        end else if (m_run) begin
            hit = 1;
            c = 2'd0;
            if (!bus.init_calib_complete) c = 2'd3;
            else if (bus.cmd_stop) c = 2'd0;
            else if (bus.bp_en && m_exec > 0 && bus.pc_id_valid && exec &&
                     bus.pc_id == bus.bp_addr) c = 2'd2;
            else if (m_mode && exec && m_steps == 1) c = 2'd1;
            else hit = 0;
            if (exec) begin
                m_exec++;
                if (m_mode && m_steps > 0) m_steps--;
            end
            if (hit) begin
                e_quit = 1;
                m_cause = c;
                m_run = 0;
                m_quit_cyc = cyc;
            end
        end else if (m_wait) begin
            if (bus.cmd_stop) begin
                m_wait = 0;
                m_cause = 2'd0;
                e_sv = 1;
            end else if (bus.init_calib_complete) begin
                m_wait = 0; m_run = 1; m_exec = 0; e_start = 1;
            end
        end else if (bus.cmd_start || bus.cmd_step) begin
            if (bus.cmd_step) begin
                m_mode = 1;
                m_steps = (bus.step_num == 0) ? 1 : int'(bus.step_num);
            end else begin
                m_mode = 0;
            end
            if (bus.init_calib_complete) begin
                m_run = 1; m_exec = 0; e_start = 1;
            end else begin
                m_wait = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare every cycle, half a period after the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cpu_start === 1'b1) begin n_start++; last_start = cyc; end
            if (bus.quit_cmd === 1'b1) begin n_quit++; last_quit = cyc; end
            if (bus.stop_valid === 1'b1) begin n_sv++; last_sv = cyc; end
            check("cpu_start", bus.cpu_start, e_start);
            check("quit_cmd", bus.quit_cmd, e_quit);
            check("cpu_running", bus.cpu_running, m_run);
            check("stop_valid", bus.stop_valid, e_sv);
            check("stop_cause", bus.stop_cause, m_cause);
            check("start_quit_excl", bus.cpu_start & bus.quit_cmd, 0);
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.cmd_start = 1'b1; tick(1); bus.cmd_start = 1'b0;
    endtask

    task automatic pulse_step();
        bus.cmd_step = 1'b1; tick(1); bus.cmd_step = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.cmd_stop = 1'b1; tick(1); bus.cmd_stop = 1'b0;
    endtask

    initial begin
        int s, t, qn, sn;
        bit stall_pat [8] = '{0, 1, 0, 1, 1, 0, 0, 0};
        bus.init_calib_complete = 1'b1;
        bus.cmd_start = 1'b0;
        bus.cmd_step = 1'b0;
        bus.cmd_stop = 1'b0;
        bus.step_num = 16'd0;
        bus.bp_en = 1'b0;
        bus.bp_addr = 32'h100;
        bus.pc_id = 32'h0;
        bus.pc_id_valid = 1'b0;
        bus.stall = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_cpu_start", bus.cpu_start, 0);
        check("rst_quit", bus.quit_cmd, 0);
        check("rst_running", bus.cpu_running, 0);
        check("rst_stop_valid", bus.stop_valid, 0);
        check("rst_cause", bus.stop_cause, 0);
        rst_n = 1'b1;
        tick(2);

        // Free run then user stop.
        s = cyc; sn = n_start; qn = n_quit;
        pulse_start();
        tick(1);
        check("t1_start_cycle", last_start, s + 1);
        check("t1_running", bus.cpu_running, 1);
        tick(17);
        t = cyc;
        pulse_stop();
        tick(8);
        check("t1_quit_cycle", last_quit, t + 1);
        check("t1_sv_cycle", last_sv, t + 6);
        check("t1_cause", bus.stop_cause, 0);
        check("t1_one_start", n_start - sn, 1);
        check("t1_one_quit", n_quit - qn, 1);

        // Step 5 with three stall cycles inserted.
        bus.step_num = 16'd5;
        s = cyc;
        pulse_step();
        for (int i = 0; i < 8; i++) begin
            bus.stall = stall_pat[i];
            tick(1);
        end
        bus.stall = 1'b0;
        tick(8);
        check("t2_quit_cycle", last_quit, s + 9);
        check("t2_sv_cycle", last_sv, s + 14);
        check("t2_cause", bus.stop_cause, 1);

        // step_num = 0 runs a single executing cycle.
        bus.step_num = 16'd0;
        s = cyc;
        pulse_step();
        tick(8);
        check("t2b_quit_cycle", last_quit, s + 2);
        check("t2b_cause", bus.stop_cause, 1);

        // Breakpoint at 0x100.
        bus.bp_en = 1'b1;
        bus.pc_id_valid = 1'b1;
        bus.pc_id = 32'hF8;
        s = cyc;
        pulse_start();
        tick(1);
        bus.pc_id = 32'hFC;
        tick(1);
        bus.pc_id = 32'h100;
        tick(1);
        bus.pc_id = 32'h104;
        tick(8);
        check("t3_quit_cycle", last_quit, s + 4);
        check("t3_cause", bus.stop_cause, 2);

        // Resume from the breakpoint address: no immediate quit.
        bus.pc_id = 32'h100;
        qn = n_quit;
        pulse_start();
        tick(1);
        bus.pc_id = 32'h104;
        tick(5);
        check("t3_resume_no_quit", n_quit - qn, 0);
        check("t3_resume_running", bus.cpu_running, 1);
        t = cyc;
        bus.pc_id = 32'h100;
        tick(1);
        bus.pc_id = 32'h104;
        tick(8);
        check("t3_second_hit", last_quit, t + 1);

        // Start while calibration is low, calibration rises 20 cycles later.
        bus.init_calib_complete = 1'b0;
        sn = n_start;
        s = cyc;
        pulse_start();
        tick(19);
        check("t4_no_start", n_start - sn, 0);
        check("t4_wait_not_running", bus.cpu_running, 0);
        bus.init_calib_complete = 1'b1;
        tick(3);
        check("t4_start_cycle", last_start, s + 21);
        bus.pc_id = 32'h100;
        tick(1);
        bus.pc_id = 32'h104;
        tick(8);
        check("t4_bp_cause", bus.stop_cause, 2);

        // Stop while waiting for calibration: stop_valid, cause 0, no quit.
        bus.init_calib_complete = 1'b0;
        qn = n_quit;
        pulse_start();
        tick(3);
        t = cyc;
        pulse_stop();
        tick(3);
        check("t4b_sv_cycle", last_sv, t + 1);
        check("t4b_cause", bus.stop_cause, 0);
        check("t4b_no_quit", n_quit - qn, 0);
        bus.init_calib_complete = 1'b1;
        tick(2);

        // Calibration loss, stop and breakpoint in one cycle; commands during drain.
        pulse_start();
        tick(4);
        qn = n_quit;
        t = cyc;
        bus.init_calib_complete = 1'b0;
        bus.cmd_stop = 1'b1;
        bus.pc_id = 32'h100;
        tick(1);
        bus.init_calib_complete = 1'b1;
        bus.cmd_stop = 1'b0;
        bus.pc_id = 32'h104;
        sn = n_start;
        tick(1);
        bus.cmd_start = 1'b1;
        bus.cmd_step = 1'b1;
        tick(1);
        bus.cmd_start = 1'b0;
        bus.cmd_step = 1'b0;
        tick(2);
        bus.cmd_start = 1'b1;
        tick(1);
        bus.cmd_start = 1'b0;
        tick(4);
        check("t5_single_quit", n_quit - qn, 1);
        check("t5_quit_cycle", last_quit, t + 1);
        check("t5_cause", bus.stop_cause, 3);
        check("t5_sv_cycle", last_sv, t + 6);
        check("t5_drain_dropped", n_start - sn, 0);
        check("t5_idle", bus.cpu_running, 0);

        // Asynchronous reset mid-run.
        pulse_start();
        tick(3);
        qn = n_quit;
        rst_n = 1'b0;
        #1;
        check("t6_rst_start", bus.cpu_start, 0);
        check("t6_rst_quit", bus.quit_cmd, 0);
        check("t6_rst_running", bus.cpu_running, 0);
        check("t6_rst_sv", bus.stop_valid, 0);
        check("t6_rst_cause", bus.stop_cause, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t6_no_quit", n_quit - qn, 0);
        s = cyc;
        pulse_start();
        tick(1);
        check("t6_restart_cycle", last_start, s + 1);
        check("t6_restart_running", bus.cpu_running, 1);
        pulse_stop();
        tick(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
